// File: rtl/mem_client_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_client_pkg
// Purpose  : Shared definitions for memory-arbiter client blocks.
//            - Default address/data widths that match the arbiter.
//            - FSM state encoding for the read requester.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_client_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 25;
  localparam int DEFAULT_DATA_WIDTH    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } req_state_e;

endpackage : mem_client_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock show-ahead FIFO. The head word is presented on
//            rdata_o whenever empty_o is low; pop_i retires it.
// Ports    : clk, reset   - clock, synchronous active-high reset
//            push_i/wdata_i - write strobe and data (ignored when full)
//            pop_i        - retire head word (ignored when empty)
//            rdata_o      - head word
//            empty_o      - no words stored
//            count_o      - number of words stored
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign w_do_push = push_i && (count_q != CNT_WIDTH'(DEPTH));
  assign w_do_pop  = pop_i && (count_q != '0);

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/memory_read_requester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : memory_read_requester
// Purpose  : Arbiter-port client that issues a burst of sequential word reads
//            and streams the returned words out in order. Request issue is
//            credit-limited so outstanding + buffered never exceeds the
//            return buffer depth, hence no returned word can be dropped.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            start, base_address, burst_len - burst launch (sampled when idle)
//            busy, done, resp_err       - status
//            req_address/wr/data/valid, req_full - arbiter request side
//            rd_data, rd_data_ready     - arbiter response side
//            out_data, out_valid, out_ready - downstream valid/ready stream
// Revision : 1.0 - initial release
// ============================================================================
module memory_read_requester
  import mem_client_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH     = 16,
  parameter int BUF_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic [LEN_WIDTH-1:0]     burst_len,
  output logic                     busy,
  output logic                     done,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] req_address,
  output logic                     req_wr,
  output logic [DATA_WIDTH-1:0]    req_data,
  output logic                     req_valid,
  input  logic                     req_full,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     rd_data_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int                 CNT_WIDTH = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_WIDTH:0] CREDIT_LIMIT = (CNT_WIDTH + 1)'(BUF_DEPTH);
  localparam logic [CNT_WIDTH:0] CREDIT_ONE   = (CNT_WIDTH + 1)'(1);

  req_state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0]     remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]     outstanding_q, outstanding_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     req_valid_q, req_valid_d;
  logic                     done_q, done_d;
  logic                     resp_err_q, resp_err_d;

  logic                     w_accept;
  logic                     w_resp_ok;
  logic                     w_resp_bad;
  logic                     w_start_ok;
  logic [CNT_WIDTH:0]       w_used;
  logic                     w_credit_now;
  logic                     w_credit_next;
  logic [CNT_WIDTH-1:0]     w_buf_count;
  logic                     w_buf_empty;
  logic                     w_pop;

  assign w_accept   = req_valid_q && !req_full;
  // A response is only legitimate while something is outstanding.
  assign w_resp_ok  = rd_data_ready && (outstanding_q != '0);
  assign w_resp_bad = rd_data_ready && (outstanding_q == '0);
  assign w_start_ok = start && (state_q == ST_IDLE);
  assign w_pop      = out_ready && !w_buf_empty;

  // Credit is judged on registered counts, which is conservative: responses
  // only move words from outstanding to buffered and pops only free space.
  assign w_used        = {1'b0, outstanding_q} + {1'b0, w_buf_count};
  // Room for a fresh request with nothing being accepted this cycle.
  assign w_credit_now  = (w_used < CREDIT_LIMIT);
  // Room for another request on top of the one being accepted this cycle.
  assign w_credit_next = ((w_used + CREDIT_ONE) < CREDIT_LIMIT);

  sync_fifo #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (BUF_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_return_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_resp_ok),
    .wdata_i (rd_data),
    .pop_i   (w_pop),
    .rdata_o (out_data),
    .empty_o (w_buf_empty),
    .count_o (w_buf_count)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      outstanding_q <= '0;
      addr_q        <= '0;
      req_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      addr_q        <= addr_d;
      req_valid_q   <= req_valid_d;
      done_q        <= done_d;
      resp_err_q    <= resp_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    addr_d        = addr_q;
    req_valid_d   = req_valid_q;
    done_d        = 1'b0;
    resp_err_d    = resp_err_q;
    outstanding_d = outstanding_q;

    // Accept and legitimate response on the same edge cancel out.
    if (w_accept && !w_resp_ok) begin
      outstanding_d = outstanding_q + CNT_WIDTH'(1);
    end else if (!w_accept && w_resp_ok) begin
      outstanding_d = outstanding_q - CNT_WIDTH'(1);
    end

    // A stray response on the start edge still flags an error.
    if (w_start_ok) begin
      resp_err_d = 1'b0;
    end
    if (w_resp_bad) begin
      resp_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            remaining_d = burst_len;
            addr_d      = base_address;
            // Words from a previous burst may still be draining.
            req_valid_d = w_credit_now;
          end
        end
      end
      ST_ISSUE: begin
        if (w_accept) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          addr_d      = addr_q + ADDRESS_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d     = ST_WAIT;
            req_valid_d = 1'b0;
          end else begin
            req_valid_d = w_credit_next;
          end
        end else if (!req_valid_q) begin
          req_valid_d = w_credit_now;
        end
      end
      ST_WAIT: begin
        if (outstanding_d == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = done_q;
    resp_err    = resp_err_q;
    req_valid   = req_valid_q;
    req_address = addr_q;
    req_wr      = 1'b0;
    req_data    = '0;
    out_valid   = !w_buf_empty;
  end

endmodule : memory_read_requester
`default_nettype wire

// File: tb/tb_memory_read_requester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_memory_read_requester
// Purpose  : Self-checking bench for memory_read_requester with an in-bench
//            arbiter/memory model (fixed 3-cycle in-order read latency) and a
//            transaction-level reference model of the client.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_read_requester;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int LW = 16;
  localparam int BD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          resp_err;
  logic [AW-1:0] req_address;
  logic          req_wr;
  logic [DW-1:0] req_data;
  logic          req_valid;
  logic          req_full;
  logic [DW-1:0] rd_data = '0;
  logic          rd_data_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  memory_read_requester #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .LEN_WIDTH     (LW),
    .BUF_DEPTH     (BD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_address  (base_address),
    .burst_len     (burst_len),
    .busy          (busy),
    .done          (done),
    .resp_err      (resp_err),
    .req_address   (req_address),
    .req_wr        (req_wr),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_full      (req_full),
    .rd_data       (rd_data),
    .rd_data_ready (rd_data_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents as a pure function of the word address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ {a[24:16], 7'h35};
  endfunction

  // ---------------- arbiter / memory model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  resp_t pend[$];
  int    cyc = 0;
  logic  inject_stray = 1'b0;

  always @(posedge clk) begin : arb_model
    resp_t r;
    #2;
    cyc++;
    if (inject_stray) begin
      rd_data_ready = 1'b1;
      rd_data       = 16'hDEAD;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r             = pend.pop_front();
      rd_data_ready = 1'b1;
      rd_data       = r.data;
    end else begin
      rd_data_ready = 1'b0;
      rd_data       = '0;
    end
  end

  // ---------------- reference model + compare ----------------
  logic [AW-1:0] exp_req[$];
  logic [DW-1:0] exp_out[$];
  logic [AW-1:0] acc_log[$];
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic          exp_err  = 1'b0;
  int            m_out = 0;
  int            m_buf = 0;
  int            m_len = 0;
  int            m_rcv = 0;
  int            done_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin : compare
    logic    acc, rsp, pp, st;
    resp_t   r;
    logic [AW-1:0] a;
    if (cyc > 0) begin
      // Outputs produced by the edge that just passed.
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("resp_err", resp_err, exp_err);
      check("out_valid", out_valid, m_buf != 0);
      if (out_valid) begin
        if (exp_out.size() > 0) check("out_data", out_data, exp_out[0]);
        else                    check("out_unexpected", out_valid, 0);
      end
      if (exp_req.size() == 0) check("req_valid_none_left", req_valid, 0);
      if (prev_stall) begin
        check("hold_valid", req_valid, 1);
        check("hold_addr", req_address, prev_addr);
      end
      if (done) done_cnt++;

      // Events happening at the coming edge.
      acc = req_valid && !req_full;
      rsp = rd_data_ready;
      pp  = out_valid && out_ready;
      st  = start && !exp_busy;
      prev_stall = req_valid && req_full && !reset;
      prev_addr  = req_address;

      if (acc) begin
        acc_log.push_back(req_address);
        r.due  = cyc + 3;
        r.data = mem_word(req_address);
        pend.push_back(r);
      end

      if (reset) begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        m_out = 0;
        m_buf = 0;
        m_rcv = 0;
        exp_req.delete();
        exp_out.delete();
      end else begin
        exp_done = 1'b0;
        if (st) begin
          exp_err = 1'b0;
          if (burst_len == 0) begin
            exp_done = 1'b1;
          end else begin
            exp_busy = 1'b1;
            m_len = int'(burst_len);
            m_rcv = 0;
            for (int k = 0; k < int'(burst_len); k++) begin
              a = AW'(base_address + k);
              exp_req.push_back(a);
              exp_out.push_back(mem_word(a));
            end
          end
        end
        if (rsp) begin
          if (m_out == 0) begin
            exp_err = 1'b1;
          end else begin
            m_out--;
            m_buf++;
            m_rcv++;
            if (m_rcv == m_len) begin
              exp_busy = 1'b0;
              exp_done = 1'b1;
            end
          end
        end
        if (acc) begin
          if (exp_req.size() == 0) check("req_unexpected", acc, 0);
          else                     check("req_address", req_address, exp_req.pop_front());
          m_out++;
          check("credit_bound", (m_out + m_buf) <= BD, 1);
        end
        if (pp && m_buf > 0) begin
          m_buf--;
          void'(exp_out.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    base_address = b;
    burst_len    = l;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || pend.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, n < 300, 1);
    tick();
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, n < 50, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    burst_len    = '0;
    req_full     = 1'b0;
    out_ready    = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", resp_err, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_address, 0);
    check("rst_out_valid", out_valid, 0);
    check("req_wr_tied", req_wr, 0);
    check("req_data_tied", req_data, 0);
    reset = 1'b0;
    tick();

    // Basic burst; hold the stream to read the first word literally.
    out_ready = 1'b0;
    acc_log.delete();
    done_cnt = 0;
    pulse_start(25'h100, 16'd4);
    check("basic_first_valid", req_valid, 1);
    check("basic_first_addr", req_address, 25'h100);
    wait_out("basic_out");
    check("basic_first_word", out_data, 16'h0135);
    out_ready = 1'b1;
    wait_idle("basic");
    check("basic_n_req", acc_log.size(), 4);
    check("basic_last_addr", acc_log[3], 25'h103);
    check("basic_done_cnt", done_cnt, 1);

    // Backpressure for 5 cycles mid-burst.
    acc_log.delete();
    pulse_start(25'h200, 16'd8);
    tick();
    tick();
    req_full = 1'b1;
    repeat (5) tick();
    req_full = 1'b0;
    wait_idle("bp");
    check("bp_n_req", acc_log.size(), 8);
    check("bp_addr2", acc_log[2], 25'h202);
    check("bp_addr7", acc_log[7], 25'h207);

    // Credit stall with the stream blocked.
    out_ready = 1'b0;
    acc_log.delete();
    pulse_start(25'h300, 16'd20);
    repeat (30) tick();
    check("credit_n_req", acc_log.size(), 8);
    check("credit_valid_low", req_valid, 0);
    check("credit_busy", busy, 1);
    out_ready = 1'b1;
    wait_idle("credit");
    check("credit_total_req", acc_log.size(), 20);
    check("credit_last_addr", acc_log[19], 25'h313);

    // Address wrap.
    acc_log.delete();
    pulse_start(25'h1FFFFFE, 16'd4);
    wait_idle("wrap");
    check("wrap_a0", acc_log[0], 25'h1FFFFFE);
    check("wrap_a1", acc_log[1], 25'h1FFFFFF);
    check("wrap_a2", acc_log[2], 25'h0000000);
    check("wrap_a3", acc_log[3], 25'h0000001);

    // Zero-length burst.
    pulse_start(25'h50, 16'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_req_valid", req_valid, 0);
    tick();
    check("len0_done_off", done, 0);
    check("len0_req_valid2", req_valid, 0);

    // Start while busy is ignored.
    acc_log.delete();
    pulse_start(25'h400, 16'd6);
    tick();
    pulse_start(25'h999, 16'd3);
    wait_idle("busy_start");
    check("busy_start_n_req", acc_log.size(), 6);
    check("busy_start_last", acc_log[5], 25'h405);

    // Stray response while idle.
    inject_stray = 1'b1;
    tick();
    inject_stray = 1'b0;
    tick();
    tick();
    check("stray_err", resp_err, 1);
    check("stray_no_data", out_valid, 0);
    acc_log.delete();
    pulse_start(25'h500, 16'd2);
    check("stray_err_cleared", resp_err, 0);
    wait_idle("after_stray");
    check("after_stray_n_req", acc_log.size(), 2);

    // Reset in the middle of a burst.
    acc_log.delete();
    pulse_start(25'h600, 16'd10);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_req_valid", req_valid, 0);
    check("midrst_req_addr", req_address, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_err", resp_err, 0);
    n = 0;
    while (pend.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("late_drain_timeout", n < 50, 1);
    tick();
    tick();
    check("late_resp_err", resp_err, 1);
    check("late_no_data", out_valid, 0);
    acc_log.delete();
    pulse_start(25'h700, 16'd3);
    check("post_rst_err_clr", resp_err, 0);
    wait_idle("post_rst");
    check("post_rst_n_req", acc_log.size(), 3);
    check("post_rst_first", acc_log[0], 25'h700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_memory_read_requester
`default_nettype wire
